// File: rtl/reaction_pkg.sv
// Shared types, constants and helpers for the reaction-timer control block.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    EARLY   = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  typedef struct packed {
    logic go;
    logic clr;
    logic led;
    logic done;
    logic early;
    logic timeout;
  } ctrl_out_t;

  localparam int          COUNT_W          = 14;
  localparam int          DELAY_W          = 15;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS        = 16'hB400;
  localparam int          DEF_CLK_PER_MS   = 100000;
  localparam int          DEF_MIN_DELAY_MS = 2000;
  localparam int          DEF_DELAY_BITS   = 13;
  localparam int          DEF_MAX_RT_MS    = 1000;
  localparam logic [15:0] DEF_LFSR_SEED    = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic ctrl_out_t moore_out(input state_t s);
    ctrl_out_t o;
    o         = '0;
    o.clr     = (s == IDLE) || (s == WAIT);
    o.go      = (s == RUN);
    o.led     = (s == RUN);
    o.done    = (s == DONE);
    o.early   = (s == EARLY);
    o.timeout = (s == TIMEOUT);
    return o;
  endfunction

endpackage

// File: rtl/reaction_ctrl_if.sv
// Button, counter and display-facing signals of the reaction-timer controller.
interface reaction_ctrl_if;
  import reaction_pkg::*;

  logic               start;
  logic               stop;
  logic               clear;
  logic [COUNT_W-1:0] count_t;
  logic               go;
  logic               clr;
  logic               led;
  logic [COUNT_W-1:0] result;
  logic               done;
  logic               early;
  logic               timeout;

  modport master (
    input  start, stop, clear, count_t,
    output go, clr, led, result, done, early, timeout
  );

  modport slave (
    output start, stop, clear, count_t,
    input  go, clr, led, result, done, early, timeout
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a nonzero seed keeps it off the all-zero lockup state.
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer control FSM: random wait, stimulus LED, counter run and result latch.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int          CLK_PER_MS   = DEF_CLK_PER_MS,
  parameter int          MIN_DELAY_MS = DEF_MIN_DELAY_MS,
  parameter int          DELAY_BITS   = DEF_DELAY_BITS,
  parameter int          MAX_RT_MS    = DEF_MAX_RT_MS,
  parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
  input  logic            clk,
  input  logic            rst_n,
  reaction_ctrl_if.master bus
);

  localparam int                 PRESC_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_MS - 1);
  localparam logic [COUNT_W-1:0] MAX_RT     = COUNT_W'(MAX_RT_MS);
  localparam logic [DELAY_W-1:0] MIN_DELAY  = DELAY_W'(MIN_DELAY_MS);

  logic [15:0]        lfsr_q;
  logic               lfsr_unused;
  logic               start_p1, stop_p1, clear_p1;
  logic               start_pulse, stop_pulse, clear_pulse;
  state_t             state;
  ctrl_out_t          outs;
  logic [COUNT_W-1:0] result_q;
  logic [PRESC_W-1:0] presc;
  logic [DELAY_W-1:0] ms_cnt;
  logic [DELAY_W-1:0] delay_ms;
  logic [DELAY_W-1:0] new_delay;

  function automatic logic [COUNT_W-1:0] sat_rt(input logic [COUNT_W-1:0] c);
    return (c > MAX_RT) ? MAX_RT : c;
  endfunction

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Only the low DELAY_BITS of the LFSR feed the delay
  assign lfsr_unused = ^lfsr_q[15:DELAY_BITS];
  assign new_delay   = MIN_DELAY + DELAY_W'(lfsr_q[DELAY_BITS-1:0]);

  assign start_pulse = bus.start & ~start_p1;
  assign stop_pulse  = bus.stop  & ~stop_p1;
  assign clear_pulse = bus.clear & ~clear_p1;

  assign bus.go      = outs.go;
  assign bus.clr     = outs.clr;
  assign bus.led     = outs.led;
  assign bus.done    = outs.done;
  assign bus.early   = outs.early;
  assign bus.timeout = outs.timeout;
  assign bus.result  = result_q;

  // Stage p1: edge-detect delay registers, FSM state and registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_p1 <= 1'b0;
      stop_p1  <= 1'b0;
      clear_p1 <= 1'b0;
      state    <= IDLE;
      outs     <= moore_out(IDLE);
      result_q <= '0;
      presc    <= '0;
      ms_cnt   <= '0;
      delay_ms <= '0;
    end else begin
      start_p1 <= bus.start;
      stop_p1  <= bus.stop;
      clear_p1 <= bus.clear;
      if (clear_pulse) begin
        state    <= IDLE;
        outs     <= moore_out(IDLE);
        result_q <= '0;
      end else begin
        unique case (state)
          IDLE, DONE, EARLY, TIMEOUT: begin
            if (start_pulse) begin
              delay_ms <= new_delay;
              presc    <= '0;
              ms_cnt   <= '0;
              state    <= WAIT;
              outs     <= moore_out(WAIT);
            end
          end
          WAIT: begin
            if (presc == PRESC_LAST) begin
              presc  <= '0;
              ms_cnt <= ms_cnt + DELAY_W'(1);
            end else begin
              presc  <= presc + PRESC_W'(1);
            end
            // A press on the expiry cycle still counts as jumping the gun
            if (stop_pulse) begin
              state <= EARLY;
              outs  <= moore_out(EARLY);
            end else if (ms_cnt == delay_ms) begin
              state <= RUN;
              outs  <= moore_out(RUN);
            end
          end
          RUN: begin
            if (stop_pulse) begin
              result_q <= sat_rt(bus.count_t);
              state    <= DONE;
              outs     <= moore_out(DONE);
            end else if (bus.count_t >= MAX_RT) begin
              result_q <= MAX_RT;
              state    <= TIMEOUT;
              outs     <= moore_out(TIMEOUT);
            end
          end
          default: begin
            state <= IDLE;
            outs  <= moore_out(IDLE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a behavioural millisecond counter and LFSR reference.
module tb_reaction_ctrl;
  import reaction_pkg::*;

  localparam int CPM  = 10;
  localparam int MIN  = 4;
  localparam int DB   = 3;
  localparam int MAXR = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] m_lfsr;
  int          m_pre;

  always #5 clk = ~clk;

  reaction_ctrl_if bus ();

  reaction_ctrl #(
    .CLK_PER_MS   (CPM),
    .MIN_DELAY_MS (MIN),
    .DELAY_BITS   (DB),
    .MAX_RT_MS    (MAXR),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference LFSR: taps 16,14,13,11, seeded on reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Millisecond counter model: +1 every CPM cycles while go, zero otherwise
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.count_t <= '0;
      m_pre       <= 0;
    end else if (!bus.go || bus.clr) begin
      bus.count_t <= '0;
      m_pre       <= 0;
    end else if (m_pre == CPM - 1) begin
      m_pre       <= 0;
      bus.count_t <= bus.count_t + 14'd1;
    end else begin
      m_pre       <= m_pre + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_measured(output int exp_cycles);
    bus.start  = 1'b1;
    exp_cycles = CPM * (MIN + int'(m_lfsr[DB-1:0])) + 1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic press_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic wait_led(output int n);
    n = 0;
    while (!bus.led && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_count(input int v, input string tag);
    int n;
    n = 0;
    while (int'(bus.count_t) != v && n < 500) begin
      tick();
      n++;
    end
    check(tag, bus.count_t, v);
  endtask

  initial begin
    int exp_c;
    int n;
    bit seen;

    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_go",      bus.go, 0);
    check("rst_clr",     bus.clr, 1);
    check("rst_led",     bus.led, 0);
    check("rst_result",  bus.result, 0);
    check("rst_flags",   {bus.done, bus.early, bus.timeout}, 0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Normal run, stop at count 7
    start_measured(exp_c);
    check("wait_clr", bus.clr, 1);
    wait_led(n);
    check("led_delay", n, exp_c);
    check("run_go_clr", {bus.go, bus.clr}, 2'b10);
    wait_count(7, "run_count7");
    press_stop();
    check("done_result", bus.result, 7);
    check("done_flag",   bus.done, 1);
    check("done_go",     bus.go, 0);
    check("done_led",    bus.led, 0);

    // Start held across DONE
    bus.start = 1'b1;
    exp_c = CPM * (MIN + int'(m_lfsr[DB-1:0])) + 1;
    tick();
    check("restart_done",   bus.done, 0);
    check("restart_keep",   bus.result, 7);
    check("restart_clr",    bus.clr, 1);
    wait_led(n);
    check("held_led_delay", n, exp_c);
    wait_count(3, "held_count3");
    press_stop();
    check("held_result", bus.result, 3);
    repeat (5) tick();
    check("held_no_retrig", {bus.done, bus.clr}, 2'b10);
    bus.start = 1'b0;
    tick();
    start_measured(exp_c);
    check("repress_wait", {bus.done, bus.clr}, 2'b01);
    wait_led(n);
    check("repress_led_delay", n, exp_c);
    repeat (3) tick();

    // Reset asserted mid-RUN
    rst_n = 1'b0;
    #1;
    check("mid_rst_go",     bus.go, 0);
    check("mid_rst_clr",    bus.clr, 1);
    check("mid_rst_led",    bus.led, 0);
    check("mid_rst_result", bus.result, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Early press 15 cycles after start
    start_measured(exp_c);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.led || bus.go) seen = 1'b1;
    end
    press_stop();
    check("early_flag",   bus.early, 1);
    check("early_no_led", seen, 0);
    check("early_go",     {bus.go, bus.led, bus.done}, 0);

    // Timeout with no stop
    start_measured(exp_c);
    check("early_cleared", bus.early, 0);
    wait_led(n);
    check("to_led_delay", n, exp_c);
    n = 0;
    while (!bus.timeout && n < 400) begin
      tick();
      n++;
    end
    check("to_latency", n, CPM * MAXR + 1);
    check("to_flag",    bus.timeout, 1);
    check("to_result",  bus.result, MAXR);
    check("to_go_led",  {bus.go, bus.led}, 0);

    // Stop in the cycle count_t reaches the limit
    start_measured(exp_c);
    check("to_cleared", bus.timeout, 0);
    wait_led(n);
    check("tie_led_delay", n, exp_c);
    wait_count(MAXR, "tie_count20");
    press_stop();
    check("tie_done",    bus.done, 1);
    check("tie_timeout", bus.timeout, 0);
    check("tie_result",  bus.result, MAXR);

    // Clear in DONE
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_result", bus.result, 0);
    check("clr_flags",  {bus.done, bus.early, bus.timeout}, 0);
    check("clr_idle",   bus.clr, 1);

    // Stop ignored in IDLE
    press_stop();
    check("idle_stop", {bus.early, bus.done, bus.clr}, 3'b001);

    // Start and clear together in WAIT
    start_measured(exp_c);
    repeat (5) tick();
    bus.start = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.clear = 1'b0;
    check("sc_clr", {bus.clr, bus.go}, 2'b10);
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (bus.led) seen = 1'b1;
    end
    check("sc_idle_no_led", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
